// File: rtl/aes_round_seq.sv
// AES round sequencer: drives load-enable, key-schedule select and round index
// for a 10/12/14-round AES datapath, with start/ready handshake and abort.
module aes_round_seq #(
  parameter int CYC_PER_RND = 5,
  parameter int KS_LOAD_CYC = 4,
  parameter int RND_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             decrypt,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             accept,
  output logic             ks_select,
  output logic [RND_W-1:0] rnd_no,
  output logic             last_rnd,
  output logic             done,
  output logic             err
);
  localparam int CNT_MAX = (CYC_PER_RND > KS_LOAD_CYC) ? CYC_PER_RND : KS_LOAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(KS_LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] RND_LAST  = CNT_W'(CYC_PER_RND - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc;
  logic [3:0]       rnd_idx;
  logic [3:0]       nr;
  logic             dec_q;
  logic             start_ok;

  assign start_ok = start && (key_len != 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc       <= '0;
      rnd_idx   <= '0;
      nr        <= 4'd10;
      dec_q     <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      accept    <= 1'b0;
      ks_select <= 1'b0;
      rnd_no    <= '0;
      last_rnd  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && (state == S_LOAD || state == S_ROUND)) begin
        state     <= S_IDLE;
        ready     <= 1'b1;
        busy      <= 1'b0;
        accept    <= 1'b0;
        ks_select <= 1'b0;
        rnd_no    <= '0;
        last_rnd  <= 1'b0;
      end else begin
        case (state)
          // DONE behaves like IDLE so a start there chains with no gap
          S_IDLE, S_DONE: begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            accept    <= 1'b0;
            ks_select <= 1'b0;
            rnd_no    <= '0;
            last_rnd  <= 1'b0;
            if (start_ok) begin
              state     <= S_LOAD;
              nr        <= 4'd10 + {1'b0, key_len, 1'b0};
              dec_q     <= decrypt;
              cyc       <= '0;
              ready     <= 1'b0;
              busy      <= 1'b1;
              accept    <= 1'b1;
              ks_select <= 1'b1;
            end else if (start) begin
              err <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cyc == LOAD_LAST) begin
              state     <= S_ROUND;
              cyc       <= '0;
              rnd_idx   <= '0;
              accept    <= 1'b0;
              ks_select <= 1'b0;
              rnd_no    <= dec_q ? RND_W'(nr - 4'd1) : RND_W'(1);
              last_rnd  <= 1'b0;
            end else begin
              cyc       <= cyc + 1'b1;
              // external key is dropped in the final load cycle
              ks_select <= (CNT_W'(cyc + 1'b1) != LOAD_LAST);
            end
          end
          S_ROUND: begin
            if (cyc == RND_LAST) begin
              cyc <= '0;
              if (rnd_idx == nr - 4'd1) begin
                state    <= S_DONE;
                done     <= 1'b1;
                ready    <= 1'b1;
                busy     <= 1'b0;
                rnd_no   <= '0;
                last_rnd <= 1'b0;
              end else begin
                rnd_idx  <= rnd_idx + 4'd1;
                rnd_no   <= dec_q ? rnd_no - RND_W'(1) : rnd_no + RND_W'(1);
                last_rnd <= (rnd_idx + 4'd1 == nr - 4'd1);
              end
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: default instance plus a fast-parameter
// instance; expected outputs come from the cycle timeline of each run.
module tb_aes_round_seq;
  logic clk = 1'b0;
  logic rst, start, decrypt, abort, psel;
  logic [1:0] key_len;

  logic d_ready, d_busy, d_accept, d_ks, d_last, d_done, d_err;
  logic p_ready, p_busy, p_accept, p_ks, p_last, p_done, p_err;
  logic [3:0] d_rnd, p_rnd;
  logic [10:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_round_seq u_dut (
    .clk(clk), .rst(rst), .start(start & ~psel), .key_len(key_len),
    .decrypt(decrypt), .abort(abort), .ready(d_ready), .busy(d_busy),
    .accept(d_accept), .ks_select(d_ks), .rnd_no(d_rnd), .last_rnd(d_last),
    .done(d_done), .err(d_err)
  );

  aes_round_seq #(.CYC_PER_RND(1), .KS_LOAD_CYC(2), .RND_W(4)) u_fast (
    .clk(clk), .rst(rst), .start(start & psel), .key_len(key_len),
    .decrypt(decrypt), .abort(abort), .ready(p_ready), .busy(p_busy),
    .accept(p_accept), .ks_select(p_ks), .rnd_no(p_rnd), .last_rnd(p_last),
    .done(p_done), .err(p_err)
  );

  assign obs = psel ? {p_ready, p_busy, p_accept, p_ks, p_last, p_done, p_err, p_rnd}
                    : {d_ready, d_busy, d_accept, d_ks, d_last, d_done, d_err, d_rnd};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // {ready,busy,accept,ks_select,last_rnd,done,err,rnd_no} for cycle c of a run
  function automatic logic [10:0] model(input int c, input int nr, input bit dec,
                                        input int L, input int C, input bit hold,
                                        input int cut);
    logic rdy, bsy, acc, ks, lst, dn;
    logic [3:0] rn;
    int P, r, k;
    rdy = 1'b1; bsy = 1'b0; acc = 1'b0; ks = 1'b0; lst = 1'b0; dn = 1'b0; rn = '0;
    P = L + nr * C + 1;
    r = hold ? c % P : c;
    if ((cut > 0 && c > cut) || (!hold && c > P)) begin
    end else if (r == 0 || r == P) begin
      dn = 1'b1;
    end else begin
      rdy = 1'b0; bsy = 1'b1;
      if (r <= L) begin
        acc = 1'b1;
        ks  = (r < L);
      end else begin
        k   = (r - L - 1) / C;
        rn  = dec ? 4'(nr - 1 - k) : 4'(k + 1);
        lst = (k == nr - 1);
      end
    end
    return {rdy, bsy, acc, ks, lst, dn, 1'b0, rn};
  endfunction

  // start is raised in cycle 0 (the current cycle on entry); checks cycles 1..endc
  task automatic run(input string nm, input int kl, input bit dec, input bit sel,
                     input int ab_at, input int rst_at, input bit hold, input int endc);
    int nr, L, C, P;
    nr = 10 + 2 * kl;
    L  = sel ? 2 : 4;
    C  = sel ? 1 : 5;
    P  = L + nr * C + 1;
    psel = sel; abort = 1'b0; rst = 1'b0;
    start = 1'b1; key_len = 2'(kl); decrypt = dec;
    for (int c = 1; c <= endc; c++) begin
      @(posedge clk); #1;
      start = hold && (c < endc);
      abort = (c == ab_at);
      rst   = (c == rst_at);
      // scramble config while busy; it must not be re-sampled
      if (hold && (c % P != 0)) begin
        key_len = 2'($urandom_range(3, 0));
        decrypt = 1'($urandom_range(1, 0));
      end else begin
        key_len = 2'(kl);
        decrypt = dec;
      end
      @(negedge clk);
      chk($sformatf("%s c%0d", nm, c), 32'(obs),
          32'(model(c, nr, dec, L, C, hold, (ab_at > 0) ? ab_at : rst_at)));
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; decrypt = 1'b0; abort = 1'b0; psel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'(obs), 32'h400);
    psel = 1'b1;
    chk("reset_fast", 32'(obs), 32'h400);
    psel = 1'b0;
    rst = 1'b0;

    run("e128", 0, 1'b0, 1'b0, 0, 0, 1'b0, 57);
    run("d256", 2, 1'b1, 1'b0, 0, 0, 1'b0, 77);
    run("b2b192", 1, 1'b0, 1'b0, 0, 0, 1'b1, 130);

    // illegal key length: single err pulse, stays idle
    start = 1'b1; key_len = 2'd3; decrypt = 1'b0;
    @(posedge clk); #1; start = 1'b0; key_len = 2'd0;
    @(negedge clk);
    chk("err c1", 32'(obs), 32'h410);
    @(posedge clk); @(negedge clk);
    chk("err c2", 32'(obs), 32'h400);

    run("abort", 0, 1'b0, 1'b0, 20, 0, 1'b0, 21);
    run("post_abort", 0, 1'b0, 1'b0, 0, 0, 1'b0, 56);
    run("rst", 0, 1'b0, 1'b0, 0, 30, 1'b0, 34);
    run("p128", 0, 1'b0, 1'b1, 0, 0, 1'b0, 15);
    run("p192d", 1, 1'b1, 1'b1, 0, 0, 1'b0, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
